// File: rtl/pdm_capture_controller.sv
// PDM capture sequencer: generates the microphone bit clock, samples the shared
// PDM data line, drives the CIC filter strobes/reset/decimation factor and masks
// filter warm-up output.
// Build option: define PDM_STEREO_EN for stereo capture (left on the falling
// clock edge, right on the rising edge). Without it the right channel is
// removed and left is sampled on the rising edge (mono microphone, L/R strapped low).
module pdm_capture_controller #(
    parameter int unsigned CLK_DIV_WIDTH  = 16,
    parameter int unsigned FLUSH_CYCLES   = 8,
    parameter int unsigned WARMUP_SAMPLES = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     enable_i,
    input  logic                     apply_i,
    input  logic [CLK_DIV_WIDTH-1:0] half_period_i,
    input  logic [31:0]              decimation_i,
    input  logic                     pdm_data_i,
    output logic                     pdm_clk_o,
    output logic                     left_pdm_o,
    output logic                     right_pdm_o,
    output logic                     left_valid_o,
    output logic                     right_valid_o,
    output logic                     reset_filter_o,
    output logic [31:0]              decimator_factor_o,
    input  logic                     filter_valid_i,
    output logic                     output_enable_o,
    output logic                     invalid_o,
    output logic                     busy_o
);

    localparam int unsigned FlushW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int unsigned WarmW  = (WARMUP_SAMPLES > 1) ? $clog2(WARMUP_SAMPLES) : 1;

    localparam logic [FlushW-1:0]        FlushLast = FlushW'(FLUSH_CYCLES - 1);
    localparam logic [WarmW-1:0]         WarmLast  = WarmW'(WARMUP_SAMPLES - 1);
    localparam logic [CLK_DIV_WIDTH-1:0] HalfMin   = CLK_DIV_WIDTH'(2);
    localparam logic [CLK_DIV_WIDTH-1:0] HalfRst   = CLK_DIV_WIDTH'(32);

    typedef enum logic [1:0] {
        StIdle,
        StFlush,
        StWarmup,
        StRun
    } state_e;

    state_e                     r_state;
    state_e                     w_state_next;
    logic [FlushW-1:0]          r_flush_cnt;
    logic [WarmW-1:0]           r_warm_cnt;
    logic [CLK_DIV_WIDTH-1:0]   r_div_cnt;
    logic [CLK_DIV_WIDTH-1:0]   r_half_period;
    logic [31:0]                r_decim;
    logic                       r_pdm_clk;
    logic                       r_left_pdm;
    logic                       r_left_valid;
    logic                       r_out_en;
    logic                       r_invalid;

    logic                       w_apply_ok;
    logic                       w_apply_bad;
    logic                       w_running;
    logic                       w_run_next;
    logic                       w_tick;
    logic                       w_left_edge;
    logic [CLK_DIV_WIDTH-1:0]   w_div_last;

    assign w_apply_ok  = apply_i && (decimation_i != 32'd0);
    assign w_apply_bad = apply_i && (decimation_i == 32'd0);
    assign w_running   = (r_state == StWarmup) || (r_state == StRun);
    assign w_run_next  = (w_state_next == StWarmup) || (w_state_next == StRun);
    assign w_div_last  = r_half_period - CLK_DIV_WIDTH'(1);
    // Only tick while staying in a clocked state, so disable/re-flush stop strobes at once.
    assign w_tick      = w_running && w_run_next && (r_div_cnt == w_div_last);

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic; a dropped enable overrides everything, including apply
    always_comb begin
        w_state_next = r_state;
        if (!enable_i) begin
            w_state_next = StIdle;
        end else begin
            case (r_state)
                StIdle: begin
                    w_state_next = StFlush;
                end
                StFlush: begin
                    if (w_apply_ok) begin
                        w_state_next = StFlush;
                    end else if (r_flush_cnt == FlushLast) begin
                        w_state_next = StWarmup;
                    end
                end
                StWarmup: begin
                    if (w_apply_ok) begin
                        w_state_next = StFlush;
                    end else if (filter_valid_i && (r_warm_cnt == WarmLast)) begin
                        w_state_next = StRun;
                    end
                end
                StRun: begin
                    if (w_apply_ok) begin
                        w_state_next = StFlush;
                    end
                end
                default: begin
                    w_state_next = StIdle;
                end
            endcase
        end
    end

    // FSM state-decoded outputs
    always_comb begin
        reset_filter_o = (r_state == StIdle) || (r_state == StFlush);
        busy_o         = (r_state == StFlush) || (r_state == StWarmup);
    end

    // Flush and warm-up counters; both restart whenever their state is (re)entered
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_flush_cnt <= '0;
            r_warm_cnt  <= '0;
        end else begin
            if ((r_state == StFlush) && (w_state_next == StFlush) && !w_apply_ok) begin
                r_flush_cnt <= r_flush_cnt + FlushW'(1);
            end else begin
                r_flush_cnt <= '0;
            end
            if ((r_state == StWarmup) && (w_state_next == StWarmup)) begin
                if (filter_valid_i) begin
                    r_warm_cnt <= r_warm_cnt + WarmW'(1);
                end
            end else begin
                r_warm_cnt <= '0;
            end
        end
    end

    // Configuration latch; a zero decimation rejects the whole apply
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_decim       <= 32'd64;
            r_half_period <= HalfRst;
            r_invalid     <= 1'b0;
        end else begin
            r_invalid <= w_apply_bad;
            if (w_apply_ok) begin
                r_decim       <= decimation_i;
                r_half_period <= (half_period_i < HalfMin) ? HalfMin : half_period_i;
            end
        end
    end

    // Half-period divider and PDM bit clock; held at zero/low outside WARMUP and RUN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_div_cnt <= '0;
            r_pdm_clk <= 1'b0;
        end else begin
            if (w_running && w_run_next && !w_tick) begin
                r_div_cnt <= r_div_cnt + CLK_DIV_WIDTH'(1);
            end else begin
                r_div_cnt <= '0;
            end
            if (!w_run_next) begin
                r_pdm_clk <= 1'b0;
            end else if (w_tick) begin
                r_pdm_clk <= ~r_pdm_clk;
            end
        end
    end

`ifdef PDM_STEREO_EN
    logic r_right_pdm;
    logic r_right_valid;
    logic w_right_edge;

    assign w_left_edge  = w_tick && r_pdm_clk;
    assign w_right_edge = w_tick && !r_pdm_clk;

    // Right channel capture on the rising clock transition
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_right_pdm   <= 1'b0;
            r_right_valid <= 1'b0;
        end else begin
            r_right_valid <= w_right_edge;
            if (w_right_edge) begin
                r_right_pdm <= pdm_data_i;
            end
        end
    end

    assign right_pdm_o   = r_right_pdm;
    assign right_valid_o = r_right_valid;
`else
    // Mono microphone drives data during the low phase, so capture on the rising transition
    assign w_left_edge   = w_tick && !r_pdm_clk;
    assign right_pdm_o   = 1'b0;
    assign right_valid_o = 1'b0;
`endif

    // Left channel capture and registered RUN gate for the post-processor
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_left_pdm   <= 1'b0;
            r_left_valid <= 1'b0;
            r_out_en     <= 1'b0;
        end else begin
            r_left_valid <= w_left_edge;
            if (w_left_edge) begin
                r_left_pdm <= pdm_data_i;
            end
            r_out_en <= (w_state_next == StRun);
        end
    end

    assign pdm_clk_o          = r_pdm_clk;
    assign left_pdm_o         = r_left_pdm;
    assign left_valid_o       = r_left_valid;
    assign decimator_factor_o = r_decim;
    assign output_enable_o    = r_out_en;
    assign invalid_o          = r_invalid;

endmodule

// File: tb/tb_pdm_capture_controller.sv
// Scoreboard bench for pdm_capture_controller: the stimulus pushes expected
// channel strobes, invalid pulses and output-enable edges; a negedge monitor
// pops and compares them as the DUT produces them.
module tb_pdm_capture_controller;

    localparam int unsigned W = 16;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          enable_i;
    logic          apply_i;
    logic [W-1:0]  half_period_i;
    logic [31:0]   decimation_i;
    logic          pdm_data_i;
    logic          filter_valid_i;
    logic          pdm_clk_o;
    logic          left_pdm_o;
    logic          right_pdm_o;
    logic          left_valid_o;
    logic          right_valid_o;
    logic          reset_filter_o;
    logic [31:0]   decimator_factor_o;
    logic          output_enable_o;
    logic          invalid_o;
    logic          busy_o;

    int n_cmp = 0;
    int n_bad = 0;

    typedef enum int {EvLeft, EvRight, EvInvalid, EvOeRise, EvOeFall} ev_e;
    typedef struct {
        ev_e  kind;
        logic bit_v;
    } ev_t;

    ev_t exp_q[$];
    bit  data_inv = 1'b0;

    pdm_capture_controller dut (
        .clk_i              (clk),
        .rst_i              (rst_i),
        .enable_i           (enable_i),
        .apply_i            (apply_i),
        .half_period_i      (half_period_i),
        .decimation_i       (decimation_i),
        .pdm_data_i         (pdm_data_i),
        .pdm_clk_o          (pdm_clk_o),
        .left_pdm_o         (left_pdm_o),
        .right_pdm_o        (right_pdm_o),
        .left_valid_o       (left_valid_o),
        .right_valid_o      (right_valid_o),
        .reset_filter_o     (reset_filter_o),
        .decimator_factor_o (decimator_factor_o),
        .filter_valid_i     (filter_valid_i),
        .output_enable_o    (output_enable_o),
        .invalid_o          (invalid_o),
        .busy_o             (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push(input ev_e k, input logic b);
        ev_t e;
        e.kind  = k;
        e.bit_v = b;
        exp_q.push_back(e);
    endtask

    task automatic sb_pop(input string name, input ev_e k, input logic b);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL %s: got event %0d bit %0d, required no event", name, k, b);
        end else begin
            e = exp_q.pop_front();
            if ((e.kind != k) || (e.bit_v !== b)) begin
                n_bad++;
                $display("FAIL %s: got event %0d bit %0d, required event %0d bit %0d",
                         name, k, b, e.kind, e.bit_v);
            end
        end
    endtask

    // Monitor: every observable event is checked against the scoreboard
    logic prev_lv = 1'b0;
    logic prev_rv = 1'b0;
    logic prev_oe = 1'b0;
    always @(negedge clk) begin
        if (!rst_i) begin
            if (left_valid_o) begin
                check("left_strobe_width", {31'd0, prev_lv}, 32'd0);
                sb_pop("left_strobe", EvLeft, left_pdm_o);
            end
            if (right_valid_o) begin
                check("right_strobe_width", {31'd0, prev_rv}, 32'd0);
                sb_pop("right_strobe", EvRight, right_pdm_o);
            end
            if (invalid_o) sb_pop("invalid_pulse", EvInvalid, 1'b0);
            if (output_enable_o !== prev_oe)
                sb_pop("oe_edge", output_enable_o ? EvOeRise : EvOeFall, 1'b0);
        end
        prev_lv = left_valid_o;
        prev_rv = right_valid_o;
        prev_oe = output_enable_o;
    end

    // Microphone model: data follows (or inverts) the bit clock, updated after each edge
    initial begin
        pdm_data_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            pdm_data_i = data_inv ? ~pdm_clk_o : pdm_clk_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    task automatic measure_flush(input string tag);
        int  n;
        int  len;
        bit  clk_seen;
        @(negedge clk);
        n = 0;
        while (!(busy_o && reset_filter_o) && n < 20) begin
            @(negedge clk);
            n++;
        end
        len = 0;
        clk_seen = 1'b0;
        while (busy_o && reset_filter_o && len < 50) begin
            if (pdm_clk_o) clk_seen = 1'b1;
            len++;
            @(negedge clk);
        end
        check({tag, "_flush_len"}, len, 8);
        check({tag, "_clk_low_in_flush"}, {31'd0, clk_seen}, 32'd0);
    endtask

    task automatic measure_clock(input string tag, input int first_req, input int period_req);
        int n;
        n = 0;
        while (!pdm_clk_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_first_rise"}, n, first_req);
        n = 0;
        while (pdm_clk_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        while (!pdm_clk_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_period"}, n, period_req);
    endtask

    task automatic pulse_fv();
        @(posedge clk);
        #1 filter_valid_i = 1'b1;
        @(posedge clk);
        #1 filter_valid_i = 1'b0;
    endtask

    task automatic do_apply(input logic [W-1:0] h, input logic [31:0] d);
        @(posedge clk);
        #1;
        apply_i       = 1'b1;
        half_period_i = h;
        decimation_i  = d;
        @(posedge clk);
        #1 apply_i = 1'b0;
    endtask

    // Expected strobes while data follows the clock: first rise, fall, second rise
    task automatic push_follow_startup();
`ifdef PDM_STEREO_EN
        push(EvRight, 1'b0);
        push(EvLeft, 1'b1);
        push(EvRight, 1'b0);
`else
        push(EvLeft, 1'b0);
        push(EvLeft, 1'b0);
`endif
    endtask

    initial begin
        rst_i          = 1'b1;
        enable_i       = 1'b1;
        apply_i        = 1'b0;
        half_period_i  = W'(32);
        decimation_i   = 32'd64;
        filter_valid_i = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pdm_clk", {31'd0, pdm_clk_o}, 32'd0);
        check("rst_reset_filter", {31'd0, reset_filter_o}, 32'd1);
        check("rst_factor", decimator_factor_o, 32'd64);
        check("rst_oe", {31'd0, output_enable_o}, 32'd0);
        check("rst_invalid", {31'd0, invalid_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_left_valid", {31'd0, left_valid_o}, 32'd0);
        check("rst_right_valid", {31'd0, right_valid_o}, 32'd0);

        // Start-up at the reset half period of 32
        push_follow_startup();
        @(posedge clk);
        #1 rst_i = 1'b0;
        measure_flush("start");
        measure_clock("start", 32, 64);

        // Warm-up masking: RUN after the fourth filter output
        push(EvOeRise, 1'b0);
        repeat (3) pulse_fv();
        @(negedge clk);
        check("warm_oe_masked", {31'd0, output_enable_o}, 32'd0);
        check("warm_busy", {31'd0, busy_o}, 32'd1);
        pulse_fv();
        @(negedge clk);
        check("run_oe", {31'd0, output_enable_o}, 32'd1);
        check("run_busy", {31'd0, busy_o}, 32'd0);

        // Rejected apply in RUN
        push(EvInvalid, 1'b0);
        do_apply(W'(5), 32'd0);
        @(negedge clk);
        check("invalid_factor_kept", decimator_factor_o, 32'd64);
        check("invalid_stays_run", {31'd0, output_enable_o}, 32'd1);
        check("invalid_reset_filter", {31'd0, reset_filter_o}, 32'd0);
        @(negedge clk);
        check("invalid_one_cycle", {31'd0, invalid_o}, 32'd0);

        // Valid apply in RUN with half period 1 (clamped to 2)
        push(EvOeFall, 1'b0);
        push_follow_startup();
        do_apply(W'(1), 32'd32);
        measure_flush("reapply");
        check("reapply_factor", decimator_factor_o, 32'd32);
        check("reapply_oe", {31'd0, output_enable_o}, 32'd0);
        measure_clock("clamped", 2, 4);

        // Inverted data: data high only while the clock is low
        data_inv = 1'b1;
`ifdef PDM_STEREO_EN
        push(EvLeft, 1'b0);
        push(EvRight, 1'b1);
        push(EvLeft, 1'b0);
        push(EvRight, 1'b1);
`else
        push(EvLeft, 1'b1);
        push(EvLeft, 1'b1);
`endif
        repeat (8) @(posedge clk);
        #1 enable_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("disable_clk_low", {31'd0, pdm_clk_o}, 32'd0);
        check("disable_reset_filter", {31'd0, reset_filter_o}, 32'd1);
        check("disable_busy", {31'd0, busy_o}, 32'd0);
        repeat (20) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        // Apply coinciding with enable falling: IDLE wins, config still latched
        @(posedge clk);
        #1 enable_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reenable_flush", {31'd0, busy_o}, 32'd1);
        @(posedge clk);
        #1;
        apply_i       = 1'b1;
        half_period_i = W'(4);
        decimation_i  = 32'd100;
        enable_i      = 1'b0;
        @(posedge clk);
        #1 apply_i = 1'b0;
        @(negedge clk);
        check("idle_wins_busy", {31'd0, busy_o}, 32'd0);
        check("idle_wins_reset_filter", {31'd0, reset_filter_o}, 32'd1);
        check("idle_wins_factor", decimator_factor_o, 32'd100);
        repeat (5) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
